mem_align_unit: RTL and testbench

Parametrised load/store alignment unit between the execute/memory stage and the data memory (Dmem or UART port). It accepts one byte/half/word/dword access per request and sign- or zero-extends load data. It generates byte write masks for stores. Accesses that straddle a memory-word boundary are split into two aligned memory beats and merged into one response.

---
 rtl/mem_align_if.sv | 49 ++++
 rtl/mem_align_unit.sv | 202 ++++++++++++++++++++
 tb/tb_mem_align_unit.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_align_if.sv
// Request, memory-beat and response bundle for the load/store alignment unit.
// The unit plugs in through the slave modport; the requester/memory side uses master.
interface mem_align_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  localparam int B = XLEN / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [B-1:0]      mem_wmask;
  logic              mem_rvalid;
  logic [XLEN-1:0]   mem_rdata;

  logic              rsp_valid;
  logic [XLEN-1:0]   rsp_data;
  logic              rsp_err;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned,
    input  req_addr, req_wdata,
    output req_ready,
    output mem_req_valid, mem_we, mem_addr,
    output mem_wdata, mem_wmask,
    input  mem_req_ready, mem_rvalid, mem_rdata,
    output rsp_valid, rsp_data, rsp_err
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned,
    output req_addr, req_wdata,
    input  req_ready,
    input  mem_req_valid, mem_we, mem_addr,
    input  mem_wdata, mem_wmask,
    output mem_req_ready, mem_rvalid, mem_rdata,
    input  rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/mem_align_unit.sv
// Load/store alignment: splits word-straddling accesses into two aligned
// beats, builds store byte masks and sign/zero-extends merged load data.
module mem_align_unit #(
  parameter int XLEN             = 32,
  parameter int ADDR_W           = 32,
  parameter int ALLOW_MISALIGNED = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  mem_align_if.slave bus
);
  localparam int B  = XLEN / 8;
  localparam int OW = $clog2(B);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE0,
    WAIT0,
    ISSUE1,
    WAIT1,
    RESP
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              we_q, we_d;
  logic              uns_q, uns_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   rdata0_q, rdata0_d;

  logic              mem_req_valid_q, mem_req_valid_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic [B-1:0]      mem_wmask_q, mem_wmask_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [XLEN-1:0]   rsp_data_q, rsp_data_d;

  logic              idle;
  logic [ADDR_W-1:0] src_addr;
  logic [1:0]        src_size;
  logic              src_we;
  logic              src_uns;
  logic [XLEN-1:0]   src_wdata;
  logic [OW-1:0]     o;
  logic [3:0]        n;
  logic [4:0]        sum;
  logic              split;
  logic              err;
  logic [2*B-1:0]    mask2;
  logic [2*XLEN-1:0] data2;
  logic [ADDR_W-1:0] base0;
  logic [2*XLEN-1:0] pair;
  logic [XLEN-1:0]   raw;
  logic [XLEN-1:0]   lo_mask;
  logic              sign;
  logic [XLEN-1:0]   ext;
  logic              hi_beat;

  assign idle = (state_q == IDLE);

  // In IDLE the live request drives the decode so ISSUE0 outputs
  // can be registered on the same edge as the capture.
  always_comb begin
    src_addr  = idle ? bus.req_addr     : addr_q;
    src_size  = idle ? bus.req_size     : size_q;
    src_we    = idle ? bus.req_we       : we_q;
    src_uns   = idle ? bus.req_unsigned : uns_q;
    src_wdata = idle ? bus.req_wdata    : wdata_q;
    o     = src_addr[OW-1:0];
    n     = 4'd1 << src_size;
    sum   = 5'(o) + 5'(n);
    split = sum > 5'(B);
    err   = ((src_size == 2'd3) && (XLEN == 32))
         || ((ALLOW_MISALIGNED == 0)
             && ((4'(o) & (n - 4'd1)) != 4'd0));
    mask2 = ~({2*B{1'b1}} << n) << o;
    data2 = {{XLEN{1'b0}}, src_wdata} << {o, 3'b000};
    base0 = {src_addr[ADDR_W-1:OW], {OW{1'b0}}};
  end

  // Merge beats, drop leading bytes, then extend from the access width.
  always_comb begin
    pair    = (state_q == WAIT1)
            ? {bus.mem_rdata, rdata0_q}
            : {{XLEN{1'b0}}, bus.mem_rdata};
    raw     = XLEN'(pair >> {o, 3'b000});
    lo_mask = ~({XLEN{1'b1}} << {n, 3'b000});
    sign    = |(raw & (lo_mask ^ (lo_mask >> 1)));
    ext     = (raw & lo_mask)
            | ({XLEN{sign & ~src_uns}} & ~lo_mask);
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    size_d   = size_q;
    we_d     = we_q;
    uns_d    = uns_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          size_d  = bus.req_size;
          we_d    = bus.req_we;
          uns_d   = bus.req_unsigned;
          wdata_d = bus.req_wdata;
          state_d = err ? RESP : ISSUE0;
        end
      end
      ISSUE0: if (bus.mem_req_ready) state_d = WAIT0;
      WAIT0: begin
        if (bus.mem_rvalid) begin
          rdata0_d = bus.mem_rdata;
          state_d  = split ? ISSUE1 : RESP;
        end
      end
      ISSUE1: if (bus.mem_req_ready) state_d = WAIT1;
      WAIT1:  if (bus.mem_rvalid) state_d = RESP;
      RESP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req_valid_d = (state_d == ISSUE0) || (state_d == ISSUE1);
    hi_beat         = (state_d == ISSUE1);
    mem_we_d        = 1'b0;
    mem_addr_d      = '0;
    mem_wdata_d     = '0;
    mem_wmask_d     = '0;
    if (mem_req_valid_d) begin
      mem_we_d   = src_we;
      mem_addr_d = hi_beat ? base0 + ADDR_W'(B) : base0;
      if (src_we) begin
        mem_wmask_d = hi_beat ? mask2[2*B-1:B] : mask2[B-1:0];
        mem_wdata_d = hi_beat ? data2[2*XLEN-1:XLEN]
                              : data2[XLEN-1:0];
      end
    end
  end

  always_comb begin
    rsp_valid_d = (state_d == RESP) && (state_q != RESP);
    rsp_err_d   = idle && (state_d == RESP);
    rsp_data_d  = rsp_data_q;
    if (rsp_valid_d) begin
      rsp_data_d = (idle || we_q) ? '0 : ext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      size_q          <= '0;
      we_q            <= 1'b0;
      uns_q           <= 1'b0;
      wdata_q         <= '0;
      rdata0_q        <= '0;
      mem_req_valid_q <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      mem_wmask_q     <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_err_q       <= 1'b0;
      rsp_data_q      <= '0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      size_q          <= size_d;
      we_q            <= we_d;
      uns_q           <= uns_d;
      wdata_q         <= wdata_d;
      rdata0_q        <= rdata0_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_we_q        <= mem_we_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      mem_wmask_q     <= mem_wmask_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_err_q       <= rsp_err_d;
      rsp_data_q      <= rsp_data_d;
    end
  end

  assign bus.req_ready     = idle;
  assign bus.mem_req_valid = mem_req_valid_q;
  assign bus.mem_we        = mem_we_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.mem_wmask     = mem_wmask_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_err       = rsp_err_q;
  assign bus.rsp_data      = rsp_data_q;
endmodule

// File: tb/tb_mem_align_unit.sv
// Scoreboard bench for mem_align_unit: one instance with misaligned splitting,
// one strict instance; a shared memory model serves whichever is selected.
module tb_mem_align_unit;
  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] rdata;
  } beat_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } rsp_t;

  logic        clk;
  logic        rst_n;
  logic        sel;
  logic        req_valid;
  logic        req_we;
  logic        req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_req_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        stray;

  logic        m_valid;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wmask;
  logic        r_ready;
  logic [31:0] r_data;
  logic        r_err;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  beat_t bq[$];
  rsp_t  rq[$];

  mem_align_if #(.XLEN(32), .ADDR_W(32)) ifa ();
  mem_align_if #(.XLEN(32), .ADDR_W(32)) ifs ();

  mem_align_unit #(
    .XLEN(32), .ADDR_W(32), .ALLOW_MISALIGNED(1)
  ) u_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));

  mem_align_unit #(
    .XLEN(32), .ADDR_W(32), .ALLOW_MISALIGNED(0)
  ) u_s (.clk(clk), .rst_n(rst_n), .bus(ifs.slave));

  assign ifa.req_valid     = req_valid & ~sel;
  assign ifs.req_valid     = req_valid & sel;
  assign ifa.req_we        = req_we;
  assign ifs.req_we        = req_we;
  assign ifa.req_size      = req_size;
  assign ifs.req_size      = req_size;
  assign ifa.req_unsigned  = req_unsigned;
  assign ifs.req_unsigned  = req_unsigned;
  assign ifa.req_addr      = req_addr;
  assign ifs.req_addr      = req_addr;
  assign ifa.req_wdata     = req_wdata;
  assign ifs.req_wdata     = req_wdata;
  assign ifa.mem_req_ready = mem_req_ready;
  assign ifs.mem_req_ready = mem_req_ready;
  assign ifa.mem_rvalid    = mem_rvalid;
  assign ifs.mem_rvalid    = mem_rvalid;
  assign ifa.mem_rdata     = mem_rdata;
  assign ifs.mem_rdata     = mem_rdata;

  assign m_valid = sel ? ifs.mem_req_valid : ifa.mem_req_valid;
  assign m_we    = sel ? ifs.mem_we : ifa.mem_we;
  assign m_addr  = sel ? ifs.mem_addr : ifa.mem_addr;
  assign m_wdata = sel ? ifs.mem_wdata : ifa.mem_wdata;
  assign m_wmask = sel ? ifs.mem_wmask : ifa.mem_wmask;
  assign r_ready = sel ? ifs.req_ready : ifa.req_ready;
  assign r_data  = sel ? ifs.rsp_data : ifa.rsp_data;
  assign r_err   = sel ? ifs.rsp_err : ifa.rsp_err;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  // Memory model: pops the expected beat on each handshake, returns its
  // read data one cycle later.
  beat_t       b_cur;
  logic        pend;
  logic [31:0] prdata;
  initial begin
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    pend       = 1'b0;
    prdata     = 32'h0;
    forever begin
      @(negedge clk);
      mem_rvalid = pend | stray;
      mem_rdata  = pend ? prdata : 32'hDEADDEAD;
      pend       = 1'b0;
      if (m_valid && mem_req_ready) begin
        if (bq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: addr 0x%08h", m_addr);
        end else begin
          b_cur = bq.pop_front();
          chk("beat_addr", m_addr, b_cur.addr);
          chk("beat_we", 32'(m_we), 32'(b_cur.we));
          if (b_cur.we) begin
            chk("beat_wmask", 32'(m_wmask), 32'(b_cur.wmask));
            chk("beat_wdata", m_wdata, b_cur.wdata);
          end
          pend   = 1'b1;
          prdata = b_cur.rdata;
        end
      end
    end
  end

  rsp_t e_cur;
  always @(negedge clk) begin
    if (rst_n && (ifa.rsp_valid || ifs.rsp_valid)) begin
      chk("rsp_src", 32'(ifs.rsp_valid), 32'(sel));
      if (rq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: data 0x%08h", r_data);
      end else begin
        e_cur = rq.pop_front();
        chk("rsp_data", r_data, e_cur.data);
        chk("rsp_err", 32'(r_err), 32'(e_cur.err));
        chk("rsp_cycle", 32'(cyc), 32'(e_cur.cyc));
      end
    end
  end

  task automatic beat(input logic [31:0] a, input logic we,
                      input logic [31:0] wd, input logic [3:0] wm,
                      input logic [31:0] rd);
    beat_t b;
    b.addr  = a;
    b.we    = we;
    b.wdata = wd;
    b.wmask = wm;
    b.rdata = rd;
    bq.push_back(b);
  endtask

  task automatic issue(input logic we, input logic [1:0] sz,
                       input logic uns, input logic [31:0] a,
                       input logic [31:0] wd, input int lat,
                       input logic [31:0] ed, input logic ee);
    rsp_t e;
    int   hc;
    int   k;
    @(negedge clk);
    chk("req_ready", 32'(r_ready), 32'd1);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = a;
    req_wdata    = wd;
    @(posedge clk);
    #1;
    hc        = cyc;
    req_valid = 1'b0;
    e.data = ed;
    e.err  = ee;
    e.cyc  = hc + lat - 1;
    rq.push_back(e);
    k = 0;
    while (rq.size() != 0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (rq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout: addr 0x%08h", a);
      rq.delete();
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    sel           = 1'b0;
    req_valid     = 1'b0;
    req_we        = 1'b0;
    req_size      = 2'd0;
    req_unsigned  = 1'b0;
    req_addr      = 32'h0;
    req_wdata     = 32'h0;
    mem_req_ready = 1'b1;
    stray         = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(ifa.req_ready), 32'd1);
    chk("rst_mem_valid", 32'(ifa.mem_req_valid), 32'd0);
    chk("rst_rsp_valid", 32'(ifa.rsp_valid), 32'd0);
    chk("rst_rsp_data", ifa.rsp_data, 32'h0);
    chk("rst_mem_addr", ifa.mem_addr, 32'h0);
    chk("rst_mem_wmask", 32'(ifa.mem_wmask), 32'h0);
    rst_n = 1'b1;

    beat(32'h100, 1'b0, 32'h0, 4'h0, 32'h8899AABB);
    issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 3, 32'h8899AABB, 1'b0);
    beat(32'h100, 1'b0, 32'h0, 4'h0, 32'h80112233);
    issue(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 3, 32'hFFFFFF80, 1'b0);
    beat(32'h100, 1'b0, 32'h0, 4'h0, 32'h80112233);
    issue(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 3, 32'h00000080, 1'b0);
    beat(32'h100, 1'b0, 32'h0, 4'h0, 32'hAB000000);
    beat(32'h104, 1'b0, 32'h0, 4'h0, 32'h000000CD);
    issue(1'b0, 2'd1, 1'b0, 32'h103, 32'h0, 5, 32'hFFFFCDAB, 1'b0);
    beat(32'h0FC, 1'b1, 32'hBEEF0000, 4'b1100, 32'h0);
    beat(32'h100, 1'b1, 32'h0000DEAD, 4'b0011, 32'h0);
    issue(1'b1, 2'd2, 1'b0, 32'h0FE, 32'hDEADBEEF, 5, 32'h0, 1'b0);
    beat(32'h100, 1'b1, 32'h3456A500, 4'b0010, 32'h0);
    issue(1'b1, 2'd0, 1'b0, 32'h101, 32'h123456A5, 3, 32'h0, 1'b0);
    beat(32'h200, 1'b1, 32'h12340000, 4'b1100, 32'h0);
    issue(1'b1, 2'd1, 1'b0, 32'h202, 32'h00001234, 3, 32'h0, 1'b0);
    beat(32'h100, 1'b0, 32'h0, 4'h0, 32'hF00D1234);
    issue(1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 3, 32'h0000F00D, 1'b0);
    beat(32'h100, 1'b0, 32'h0, 4'h0, 32'h00008001);
    issue(1'b0, 2'd1, 1'b0, 32'h100, 32'h0, 3, 32'hFFFF8001, 1'b0);
    beat(32'hFFFFFFFC, 1'b0, 32'h0, 4'h0, 32'h11223344);
    beat(32'h00000000, 1'b0, 32'h0, 4'h0, 32'h55667788);
    issue(1'b0, 2'd2, 1'b0, 32'hFFFFFFFE, 32'h0, 5, 32'h77881122, 1'b0);
    issue(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 1, 32'h0, 1'b1);

    @(negedge clk);
    sel = 1'b1;
    issue(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 1, 32'h0, 1'b1);
    beat(32'h104, 1'b0, 32'h0, 4'h0, 32'h12345678);
    issue(1'b0, 2'd2, 1'b0, 32'h104, 32'h0, 3, 32'h12345678, 1'b0);
    issue(1'b0, 2'd1, 1'b0, 32'h101, 32'h0, 1, 32'h0, 1'b1);
    issue(1'b1, 2'd2, 1'b0, 32'h106, 32'hCAFEF00D, 1, 32'h0, 1'b1);
    issue(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 1, 32'h0, 1'b1);

    // Abandon a load in WAIT0; its read data lands during reset.
    @(negedge clk);
    sel = 1'b0;
    beat(32'h200, 1'b0, 32'h0, 4'h0, 32'h12345678);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_size  = 2'd2;
    req_addr  = 32'h200;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(ifa.req_ready), 32'd1);
    chk("post_rst_mem_valid", 32'(ifa.mem_req_valid), 32'd0);
    chk("post_rst_rsp", 32'(ifa.rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    stray = 1'b1;
    @(posedge clk);
    #1;
    stray = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stray_rsp", 32'(ifa.rsp_valid), 32'd0);
    end
    chk("stray_ready", 32'(ifa.req_ready), 32'd1);
    chk("beat_q_empty", 32'(bq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end
endmodule
